video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the arcade video path.
- Produces pixel/line counters, blanking, syncs, display-enable and frame/line event pulses from a pixel-clock enable in the system clock domain.
- Generalises the fixed 6 MHz 384x264 generator with:
  - per-instance geometry and counter widths;
  - configurable sync polarity;
  - frame-synchronous, wrap-safe sync offsets;
  - event pulses for the CPU interrupt logic and the line buffers.

---
 rtl/video_timing_pkg.sv | 45 ++++
 rtl/video_timing_if.sv | 30 +++
 rtl/timing_axis.sv | 86 ++++++++
 rtl/video_timing_gen.sv | 85 ++++++++
 tb/tb_video_timing_gen.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared geometry types, default 6 MHz 384x264 raster constants and window/offset helpers
// for the raster timing generator.
package video_timing_pkg;

    typedef struct packed {
        int total;
        int bl_start;
        int bl_end;
        int s_start;
        int s_end;
    } timing_t;

    localparam timing_t DEF_H_TIMING = '{total: 32'd383, bl_start: 32'd256, bl_end: 32'd0,
                                         s_start: 32'd300, s_end: 32'd332};
    localparam timing_t DEF_V_TIMING = '{total: 32'd263, bl_start: 32'd239, bl_end: 32'd16,
                                         s_start: 32'd251, s_end: 32'd259};

    // Shifted position folded back onto an axis of n positions by a single add or subtract.
    function automatic int wrap_pos(input int pos, input int ofs, input int n);
        int p;
        p = pos + ofs;
        if (p < 32'sd0) begin
            p = p + n;
        end else if (p >= n) begin
            p = p - n;
        end else begin
            p = p;
        end
        return p;
    endfunction

    // Half-open window [s,e); s>e wraps through the end of the axis, s==e is empty.
    function automatic logic in_window(input int x, input int s, input int e);
        logic act;
        if (s < e) begin
            act = (x >= s) && (x < e);
        end else if (s > e) begin
            act = (x >= s) || (x < e);
        end else begin
            act = 1'b0;
        end
        return act;
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster timing bundle: pixel enable and sync offsets in, counters, blanks, syncs and events out.
interface video_timing_if #(
    parameter int HW    = 9,
    parameter int VW    = 9,
    parameter int OFS_W = 4
);
    logic             clk_pix_en;
    logic [OFS_W-1:0] hs_offset;
    logic [OFS_W-1:0] vs_offset;
    logic [HW-1:0]    hc;
    logic [VW-1:0]    vc;
    logic             hbl;
    logic             vbl;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             line_start;
    logic             frame_start;
    logic             vbl_irq;

    modport master (
        input  clk_pix_en, hs_offset, vs_offset,
        output hc, vc, hbl, vbl, hsync, vsync, de, line_start, frame_start, vbl_irq
    );

    modport slave (
        output clk_pix_en, hs_offset, vs_offset,
        input  hc, vc, hbl, vbl, hsync, vsync, de, line_start, frame_start, vbl_irq
    );
endinterface

// File: rtl/timing_axis.sv
// One raster axis: wrapping counter, blank window and frame-shadowed offset sync window.
// Decode registers always see the next counter value so they stay aligned with the count.
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int   W        = 9,
    parameter int   OFS_W    = 4,
    parameter int   TOTAL    = 383,
    parameter int   BL_START = 256,
    parameter int   BL_END   = 0,
    parameter int   S_START  = 300,
    parameter int   S_END    = 332,
    parameter logic POL      = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             load,
    input  logic [OFS_W-1:0] offset,
    output logic [W-1:0]     cnt,
    output logic             wrap,
    output logic             blank,
    output logic             blank_nx,
    output logic             sync
);

    localparam int N = TOTAL + 32'sd1;

    if ((TOTAL >= (32'sd1 <<< W)) || (BL_START > TOTAL) || (BL_END > TOTAL) ||
        (S_START > TOTAL) || (S_END > TOTAL)) begin : g_bad_geometry
        $error("timing_axis: position or total does not fit the axis");
    end

    logic [W-1:0]     cnt_r;
    logic [W-1:0]     cnt_nx_s;
    logic [OFS_W-1:0] ofs_r;
    logic [OFS_W-1:0] ofs_nx_s;
    logic             blank_r;
    logic             blank_nx_s;
    logic             sync_r;
    logic             sync_act_s;
    logic             wrap_s;
    int               s_pos_s;
    int               e_pos_s;

    assign wrap_s = (cnt_r == W'(TOTAL));

    // Next count and offset shadow; reset is folded in so the decode lands on position 0.
    always_comb begin
        cnt_nx_s = cnt_r;
        ofs_nx_s = ofs_r;
        if (reset) begin
            cnt_nx_s = '0;
            ofs_nx_s = '0;
        end else if (adv) begin
            cnt_nx_s = wrap_s ? '0 : cnt_r + W'(1'b1);
            ofs_nx_s = load ? offset : ofs_r;
        end else begin
            cnt_nx_s = cnt_r;
            ofs_nx_s = ofs_r;
        end
    end

    // Window decode of the next position with the offset that will be in force there.
    always_comb begin
        s_pos_s    = wrap_pos(S_START, int'($signed(ofs_nx_s)), N);
        e_pos_s    = wrap_pos(S_END, int'($signed(ofs_nx_s)), N);
        blank_nx_s = ~in_window(int'(cnt_nx_s), BL_END, BL_START);
        sync_act_s = in_window(int'(cnt_nx_s), s_pos_s, e_pos_s);
    end

    // Counter, shadow and decode registers; holding inputs reproduce the same values.
    always_ff @(posedge clk) begin
        cnt_r   <= cnt_nx_s;
        ofs_r   <= ofs_nx_s;
        blank_r <= blank_nx_s;
        sync_r  <= sync_act_s ? POL : ~POL;
    end

    assign cnt      = cnt_r;
    assign wrap     = wrap_s;
    assign blank    = blank_r;
    assign blank_nx = blank_nx_s;
    assign sync     = sync_r;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: horizontal and vertical axes stepped by a pixel enable,
// plus registered display enable and line/frame/vblank event pulses.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   HW         = 9,
    parameter int   VW         = 9,
    parameter int   OFS_W      = 4,
    parameter int   H_TOTAL    = DEF_H_TIMING.total,
    parameter int   H_BL_START = DEF_H_TIMING.bl_start,
    parameter int   H_BL_END   = DEF_H_TIMING.bl_end,
    parameter int   HS_START   = DEF_H_TIMING.s_start,
    parameter int   HS_END     = DEF_H_TIMING.s_end,
    parameter int   V_TOTAL    = DEF_V_TIMING.total,
    parameter int   V_BL_START = DEF_V_TIMING.bl_start,
    parameter int   V_BL_END   = DEF_V_TIMING.bl_end,
    parameter int   VS_START   = DEF_V_TIMING.s_start,
    parameter int   VS_END     = DEF_V_TIMING.s_end,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    video_timing_if.master   vid
);

    localparam timing_t H_T = '{total: H_TOTAL, bl_start: H_BL_START, bl_end: H_BL_END,
                                s_start: HS_START, s_end: HS_END};
    localparam timing_t V_T = '{total: V_TOTAL, bl_start: V_BL_START, bl_end: V_BL_END,
                                s_start: VS_START, s_end: VS_END};

    logic h_wrap_s;
    logic v_wrap_s;
    logic h_blank_nx_s;
    logic v_blank_nx_s;
    logic v_adv_s;
    logic frame_wrap_s;
    logic line_start_r;
    logic frame_start_r;
    logic vbl_irq_r;
    logic de_r;

    assign v_adv_s      = vid.clk_pix_en & h_wrap_s;
    assign frame_wrap_s = h_wrap_s & v_wrap_s;

    // The vertical axis only steps on line wraps, so vsync can change only at hc=0.
    timing_axis #(
        .W(HW), .OFS_W(OFS_W), .TOTAL(H_T.total), .BL_START(H_T.bl_start), .BL_END(H_T.bl_end),
        .S_START(H_T.s_start), .S_END(H_T.s_end), .POL(HS_POL)
    ) u_h_axis (
        .clk(clk), .reset(reset), .adv(vid.clk_pix_en), .load(frame_wrap_s),
        .offset(vid.hs_offset), .cnt(vid.hc), .wrap(h_wrap_s), .blank(vid.hbl),
        .blank_nx(h_blank_nx_s), .sync(vid.hsync)
    );

    timing_axis #(
        .W(VW), .OFS_W(OFS_W), .TOTAL(V_T.total), .BL_START(V_T.bl_start), .BL_END(V_T.bl_end),
        .S_START(V_T.s_start), .S_END(V_T.s_end), .POL(VS_POL)
    ) u_v_axis (
        .clk(clk), .reset(reset), .adv(v_adv_s), .load(v_wrap_s),
        .offset(vid.vs_offset), .cnt(vid.vc), .wrap(v_wrap_s), .blank(vid.vbl),
        .blank_nx(v_blank_nx_s), .sync(vid.vsync)
    );

    // Event pulses and display enable, aligned with the counter values they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            vbl_irq_r     <= 1'b0;
            de_r          <= ~h_blank_nx_s & ~v_blank_nx_s;
        end else begin
            line_start_r  <= vid.clk_pix_en & h_wrap_s;
            frame_start_r <= vid.clk_pix_en & frame_wrap_s;
            vbl_irq_r     <= vid.clk_pix_en & v_blank_nx_s & ~vid.vbl;
            de_r          <= ~h_blank_nx_s & ~v_blank_nx_s;
        end
    end

    assign vid.line_start  = line_start_r;
    assign vid.frame_start = frame_start_r;
    assign vid.vbl_irq     = vbl_irq_r;
    assign vid.de          = de_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: instance A uses the default 384x264 raster, instance B a 20x12 raster with
// wrapping hsync window and active-high vsync so whole frames fit in a short run.
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_a = 0;
    int   n_b = 0;
    int   win_cur = 0;
    int   win_pend = 0;
    int   de_cnt = 0;
    int   irq_cnt = 0;
    int   last_fs = -1;

    always #5 clk = ~clk;

    video_timing_if ia ();
    video_timing_if #(.HW(5), .VW(4), .OFS_W(4)) ib ();

    video_timing_gen u_a (.clk(clk), .reset(reset_a), .vid(ia));

    video_timing_gen #(
        .HW(5), .VW(4), .OFS_W(4),
        .H_TOTAL(19), .H_BL_START(16), .H_BL_END(0), .HS_START(15), .HS_END(19),
        .V_TOTAL(11), .V_BL_START(9), .V_BL_END(2), .VS_START(9), .VS_END(11),
        .HS_POL(1'b0), .VS_POL(1'b1)
    ) u_b (.clk(clk), .reset(reset_b), .vid(ib));

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Default raster: blank 256..383 / 239..15, hsync low 300..331, vsync low 251..258.
    task automatic chk_a(input logic en);
        int hc_e;
        int vc_e;
        hc_e = n_a % 384;
        vc_e = (n_a / 384) % 264;
        check_eq("a_hc", int'(ia.hc), hc_e);
        check_eq("a_vc", int'(ia.vc), vc_e);
        check_eq("a_hbl", int'(ia.hbl), int'(hc_e >= 256));
        check_eq("a_vbl", int'(ia.vbl), int'(vc_e >= 239 || vc_e < 16));
        check_eq("a_hsync", int'(ia.hsync), int'(!(hc_e >= 300 && hc_e < 332)));
        check_eq("a_vsync", int'(ia.vsync), int'(!(vc_e >= 251 && vc_e < 259)));
        check_eq("a_de", int'(ia.de), int'(hc_e < 256 && vc_e >= 16 && vc_e < 239));
        check_eq("a_line_start", int'(ia.line_start), int'(en && hc_e == 0));
        check_eq("a_frame_start", int'(ia.frame_start), int'(en && hc_e == 0 && vc_e == 0));
        check_eq("a_vbl_irq", int'(ia.vbl_irq), int'(en && hc_e == 0 && vc_e == 239));
    endtask

    task automatic step_a(input logic en);
        ia.clk_pix_en = en;
        ib.clk_pix_en = 1'b0;
        @(posedge clk);
        #1;
        if (en) n_a++;
        chk_a(en);
    endtask

    // Small raster: hsync window per latched offset, vsync high on lines 9..10.
    task automatic chk_b(input logic en);
        int   hc_e;
        int   vc_e;
        logic act;
        hc_e = n_b % 20;
        vc_e = (n_b / 20) % 12;
        case (win_cur)
            0:       act = (hc_e >= 15 && hc_e < 19);
            1:       act = (hc_e >= 7 && hc_e < 11);
            default: act = (hc_e >= 18 || hc_e < 2);
        endcase
        check_eq("b_hc", int'(ib.hc), hc_e);
        check_eq("b_vc", int'(ib.vc), vc_e);
        check_eq("b_hbl", int'(ib.hbl), int'(hc_e >= 16));
        check_eq("b_vbl", int'(ib.vbl), int'(vc_e >= 9 || vc_e < 2));
        check_eq("b_hsync", int'(ib.hsync), int'(!act));
        check_eq("b_vsync", int'(ib.vsync), int'(vc_e >= 9 && vc_e < 11));
        check_eq("b_de", int'(ib.de), int'(hc_e < 16 && vc_e >= 2 && vc_e < 9));
        check_eq("b_line_start", int'(ib.line_start), int'(en && hc_e == 0));
        check_eq("b_frame_start", int'(ib.frame_start), int'(en && hc_e == 0 && vc_e == 0));
        check_eq("b_vbl_irq", int'(ib.vbl_irq), int'(en && hc_e == 0 && vc_e == 9));
    endtask

    task automatic step_b(input logic en);
        ia.clk_pix_en = 1'b0;
        ib.clk_pix_en = en;
        @(posedge clk);
        #1;
        if (en) begin
            n_b++;
            if (n_b % 240 == 0) begin
                win_cur = win_pend;
                de_cnt  = 0;
                irq_cnt = 0;
            end
        end
        chk_b(en);
        if (en && ib.de) de_cnt++;
        if (ib.vbl_irq) irq_cnt++;
        if (ib.frame_start) begin
            if (last_fs >= 0) check_eq("b_frame_period", n_b - last_fs, 240);
            last_fs = n_b;
        end
        if (en && n_b % 240 == 239) begin
            check_eq("b_de_per_frame", de_cnt, 16 * 7);
            check_eq("b_irq_per_frame", irq_cnt, 1);
        end
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        ia.clk_pix_en = 1'b0;
        ib.clk_pix_en = 1'b0;
        ia.hs_offset = 4'd0;
        ia.vs_offset = 4'd0;
        ib.hs_offset = 4'd0;
        ib.vs_offset = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        chk_a(1'b0);
        chk_b(1'b0);

        // A: enable on every 4th clock across a full line and into the next.
        for (int i = 0; i < 386; i++) begin
            step_a(1'b1);
            repeat (3) step_a(1'b0);
        end
        // A mid-frame offset change must not move hsync within this frame.
        ia.hs_offset = 4'b1000;
        while (n_a < 768) step_a(1'b1);
        // A frozen right after a line_start: nothing moves, no repeated pulse.
        repeat (50) step_a(1'b0);
        repeat (5) step_a(1'b1);

        // B: offsets changed mid-frame take effect only from the next frame.
        for (int i = 0; i < 860; i++) begin
            if (n_b == 100) begin
                ib.hs_offset = 4'b1000;
                win_pend = 1;
            end
            if (n_b == 340) begin
                ib.hs_offset = 4'd3;
                win_pend = 2;
            end
            step_b(1'b1);
        end
        // B: one-clock reset mid-frame without a pixel enable.
        check_eq("b_pre_reset_vc", int'(ib.vc), 7);
        reset_b = 1'b1;
        ib.clk_pix_en = 1'b0;
        @(posedge clk);
        #1;
        reset_b = 1'b0;
        n_b = 0;
        win_cur = 0;
        de_cnt = 0;
        irq_cnt = 0;
        last_fs = -1;
        chk_b(1'b0);
        repeat (25) step_b(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
